tile_mover: RTL and testbench
=============================

Name: tile_mover

Overview:
- Per-object motion controller. It sequences the x_pos/y_pos inputs of a rectangle/sprite drawing stage in the VGA pipeline.
- Holds the object's grid tile and pixel offset and accepts level-sensitive direction requests.
- Before each tile-to-tile move it asks the maze map whether the target tile is a wall, then advances the object STEP pixels per frame until it reaches the next tile.
- Sits between keyboard/AI direction sources and the draw stage. Position updates once per frame, so a frame is never drawn mid-update.

Parameters:
- TILE, 40, tile edge in pixels. Must be a multiple of STEP.
- STEP, 2, pixels moved per frame tick.
- GRID_COLS, 20, number of tile columns (800 px / 40).
- GRID_ROWS, 15, number of tile rows (600 px / 40).
- START_COL, 1, column after reset.
- START_ROW, 1, row after reset.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- vsync_in  in  1  vsync from the timing pipeline; its rising edge is the frame tick
- dir_up  in  1  move request up (level)
- dir_down  in  1  move request down (level)
- dir_left  in  1  move request left (level)
- dir_right  in  1  move request right (level)
- map_req  out  1  wall-lookup request
- map_col  out  5  column being queried
- map_row  out  4  row being queried
- map_ack  in  1  lookup done; map_wall valid in the same cycle
- map_wall  in  1  1 = queried tile is a wall
- x_pos  out  12  object left edge in pixels, to the draw stage
- y_pos  out  12  object top edge in pixels, to the draw stage
- col  out  5  current tile column
- row  out  4  current tile row
- moving  out  1  high while in state MOVE

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk. On reset:
  - state=IDLE, col=START_COL, row=START_ROW, offset=0
  - x_pos=START_COL*TILE, y_pos=START_ROW*TILE
  - map_req=0, map_col=0, map_row=0, moving=0
  - vsync_prev=1, so no spurious tick is generated after reset.
- Frame tick: tick = vsync_in & ~vsync_prev, a single clk pulse.
- IDLE:
  - On a tick with any direction active, select one direction with priority up > down > left > right.
  - Target = col±1 or row±1.
  - If the target is outside 0..GRID_COLS-1 or 0..GRID_ROWS-1, stay in IDLE and issue no request.
  - Otherwise latch dir, drive map_col/map_row with the target, assert map_req next cycle, go to QUERY.
- QUERY:
  - map_req, map_col and map_row are held stable until map_ack.
  - map_ack is ignored when map_req=0.
  - On map_ack: map_req=0 the next cycle. If map_wall=1, go to IDLE. If map_wall=0, go to MOVE with offset=0.
  - Frame ticks during QUERY are discarded, not queued.
- MOVE:
  - On each tick, offset += STEP, and x_pos/y_pos are updated in the latched direction (registered, 1 clk after the tick).
  - Direction inputs are ignored until the move completes.
  - When offset reaches TILE: commit col/row to the target, offset=0, go to IDLE. The pixel position now equals target*TILE exactly.
  - A new move can start on the next tick, so there is a one-frame pause between tiles.
- Position arithmetic is 12-bit unsigned: x_pos = col*TILE ± offset (horizontal moves), y_pos analogous. No wrap occurs because targets are bounds-checked.
- The latched direction is fixed per move. A simultaneous tick and map_ack in QUERY: the ack is taken and the tick is dropped.
- Reset asserted mid-QUERY or mid-MOVE returns immediately to the reset values. An outstanding map request is abandoned; the map responder must tolerate this.

Decomposition:
- Shared package:
  - direction encoding constants DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3
  - state encodings IDLE/QUERY/MOVE
  - TILE, GRID_COLS, GRID_ROWS defaults, reused by the map ROM and the draw stages
- One natural sub-module: vsync_tick, a rising-edge pulse generator with asynchronous reset to 1, reused by other frame-rate controllers.

Test Plan:
- Reset: assert rst with vsync_in=1 → x_pos=40, y_pos=40, col=1, row=1, map_req=0, moving=0. After release, no tick until vsync falls and rises.
- Free move: dir_right=1, map_wall=0, ack 1 cycle after req → map_col=2, map_row=1. After 20 ticks x_pos steps 42, 44, …, 80, then col=2 and moving=0. y_pos stays 40 throughout.
- Wall: dir_down=1, ack with map_wall=1 → map_row=2 queried, state back to IDLE, x_pos/y_pos unchanged, moving never asserted.
- Boundary: from reset, move left to col=0 (wall=0), then hold dir_left → on later ticks map_req stays 0 and x_pos stays 0.
- Priority plus slow ack: dir_up=1 and dir_left=1 together → query (1,0). Delay ack 3 frames → map_req and map_col/map_row stable throughout, the 3 ticks are dropped, and motion starts on the first tick after ack.
- Reset mid-move: assert rst after 7 ticks of a right move (x_pos=54) → x_pos=40 immediately, state IDLE, moving=0.

Source files
------------

// File: rtl/tile_mover_pkg.sv
// Shared definitions for the tile-based motion controllers, map ROM and draw stages.
package tile_mover_pkg;

    localparam int TILE_DEF      = 40;
    localparam int STEP_DEF      = 2;
    localparam int GRID_COLS_DEF = 20;
    localparam int GRID_ROWS_DEF = 15;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        QUERY = 2'd1,
        MOVE  = 2'd2
    } state_e;

endpackage

// File: rtl/tile_mover_vsync_tick.sv
// Single-cycle frame tick on the rising edge of vsync. The history register resets
// to 1 so a vsync that is already high at reset release does not count as an edge.
module vsync_tick (
    input  logic clk,
    input  logic rst,
    input  logic vsync_i,
    output logic tick_o
);

    logic vsync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q <= 1'b1;
        end else begin
            vsync_q <= vsync_i;
        end
    end

    assign tick_o = vsync_i & ~vsync_q;

endmodule

// File: rtl/tile_mover.sv
// Per-object motion controller: checks the target tile with the maze map, then
// slides the object STEP pixels per frame until it lands on the next tile.
module tile_mover
    import tile_mover_pkg::*;
#(
    parameter int TILE      = TILE_DEF,
    parameter int STEP      = STEP_DEF,
    parameter int GRID_COLS = GRID_COLS_DEF,
    parameter int GRID_ROWS = GRID_ROWS_DEF,
    parameter int START_COL = 1,
    parameter int START_ROW = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync_in,
    input  logic        dir_up,
    input  logic        dir_down,
    input  logic        dir_left,
    input  logic        dir_right,
    output logic        map_req,
    output logic [4:0]  map_col,
    output logic [3:0]  map_row,
    input  logic        map_ack,
    input  logic        map_wall,
    output logic [11:0] x_pos,
    output logic [11:0] y_pos,
    output logic [4:0]  col,
    output logic [3:0]  row,
    output logic        moving
);

    localparam logic [11:0] TILE_W    = 12'(TILE);
    localparam logic [11:0] STEP_W    = 12'(STEP);
    localparam logic [4:0]  LAST_COL  = 5'(GRID_COLS - 1);
    localparam logic [3:0]  LAST_ROW  = 4'(GRID_ROWS - 1);
    localparam logic [4:0]  RST_COL   = 5'(START_COL);
    localparam logic [3:0]  RST_ROW   = 4'(START_ROW);
    localparam logic [11:0] RST_X     = 12'(START_COL * TILE);
    localparam logic [11:0] RST_Y     = 12'(START_ROW * TILE);

    function automatic logic [11:0] tile_to_pix(input logic [11:0] t);
        logic [23:0] p;
        p = t * TILE_W;
        return p[11:0];
    endfunction

    state_e      state_q, state_d;
    logic [4:0]  col_q, col_d;
    logic [3:0]  row_q, row_d;
    logic [11:0] offset_q, offset_d;
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic [1:0]  dir_q, dir_d;
    logic        map_req_q, map_req_d;
    logic [4:0]  map_col_q, map_col_d;
    logic [3:0]  map_row_q, map_row_d;

    logic        tick;
    logic        any_dir;
    logic [1:0]  req_dir;
    logic [4:0]  tgt_col;
    logic [3:0]  tgt_row;
    logic        tgt_ok;
    logic [11:0] offset_next;
    logic [11:0] col_pix;
    logic [11:0] row_pix;

    vsync_tick u_tick (
        .clk     (clk),
        .rst     (rst),
        .vsync_i (vsync_in),
        .tick_o  (tick)
    );

    assign any_dir = dir_up | dir_down | dir_left | dir_right;

    // Direction priority up > down > left > right, with the edge-of-grid check.
    always_comb begin
        req_dir = DIR_RIGHT;
        tgt_col = col_q;
        tgt_row = row_q;
        tgt_ok  = 1'b0;
        if (dir_up) begin
            req_dir = DIR_UP;
            tgt_row = row_q - 4'd1;
            tgt_ok  = (row_q != 4'd0);
        end else if (dir_down) begin
            req_dir = DIR_DOWN;
            tgt_row = row_q + 4'd1;
            tgt_ok  = (row_q < LAST_ROW);
        end else if (dir_left) begin
            req_dir = DIR_LEFT;
            tgt_col = col_q - 5'd1;
            tgt_ok  = (col_q != 5'd0);
        end else if (dir_right) begin
            req_dir = DIR_RIGHT;
            tgt_col = col_q + 5'd1;
            tgt_ok  = (col_q < LAST_COL);
        end
    end

    assign offset_next = offset_q + STEP_W;
    assign col_pix     = tile_to_pix({7'd0, col_q});
    assign row_pix     = tile_to_pix({8'd0, row_q});

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        offset_d  = offset_q;
        x_d       = x_q;
        y_d       = y_q;
        dir_d     = dir_q;
        map_req_d = map_req_q;
        map_col_d = map_col_q;
        map_row_d = map_row_q;

        case (state_q)
            IDLE: begin
                if (tick && any_dir && tgt_ok) begin
                    dir_d     = req_dir;
                    map_col_d = tgt_col;
                    map_row_d = tgt_row;
                    map_req_d = 1'b1;
                    state_d   = QUERY;
                end
            end
            QUERY: begin
                // Frame ticks here are simply not acted on; an ack wins over a coincident tick.
                if (map_req_q && map_ack) begin
                    map_req_d = 1'b0;
                    offset_d  = 12'd0;
                    state_d   = map_wall ? IDLE : MOVE;
                end
            end
            MOVE: begin
                if (tick) begin
                    offset_d = offset_next;
                    case (dir_q)
                        DIR_UP:    y_d = row_pix - offset_next;
                        DIR_DOWN:  y_d = row_pix + offset_next;
                        DIR_LEFT:  x_d = col_pix - offset_next;
                        default:   x_d = col_pix + offset_next;
                    endcase
                    // The latched query target doubles as the commit target.
                    if (offset_next >= TILE_W) begin
                        col_d    = map_col_q;
                        row_d    = map_row_q;
                        offset_d = 12'd0;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            col_q     <= RST_COL;
            row_q     <= RST_ROW;
            offset_q  <= 12'd0;
            x_q       <= RST_X;
            y_q       <= RST_Y;
            dir_q     <= DIR_UP;
            map_req_q <= 1'b0;
            map_col_q <= 5'd0;
            map_row_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            offset_q  <= offset_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dir_q     <= dir_d;
            map_req_q <= map_req_d;
            map_col_q <= map_col_d;
            map_row_q <= map_row_d;
        end
    end

    assign map_req = map_req_q;
    assign map_col = map_col_q;
    assign map_row = map_row_q;
    assign x_pos   = x_q;
    assign y_pos   = y_q;
    assign col     = col_q;
    assign row     = row_q;
    assign moving  = (state_q == MOVE);

endmodule

// File: tb/tb_tile_mover.sv
// Directed bench for tile_mover: a vector table of frame/ack/reset operations plus
// hand-written sequences for post-reset tick suppression, slow ack and reset mid-move.
module tb_tile_mover;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vsync_in = 1'b1;
    logic        dir_up = 1'b0, dir_down = 1'b0, dir_left = 1'b0, dir_right = 1'b0;
    logic        map_ack = 1'b0, map_wall = 1'b0;
    logic        map_req;
    logic [4:0]  map_col;
    logic [3:0]  map_row;
    logic [11:0] x_pos, y_pos;
    logic [4:0]  col;
    logic [3:0]  row;
    logic        moving;

    int errors = 0;
    int checks = 0;

    tile_mover dut (
        .clk       (clk),
        .rst       (rst),
        .vsync_in  (vsync_in),
        .dir_up    (dir_up),
        .dir_down  (dir_down),
        .dir_left  (dir_left),
        .dir_right (dir_right),
        .map_req   (map_req),
        .map_col   (map_col),
        .map_row   (map_row),
        .map_ack   (map_ack),
        .map_wall  (map_wall),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .col       (col),
        .row       (row),
        .moving    (moving)
    );

    always #5 clk = ~clk;

    typedef enum logic [1:0] { OP_RST, OP_TICK, OP_ACK } op_e;

    // dirs packs {up, down, left, right}.
    typedef struct {
        op_e         op;
        logic [3:0]  dirs;
        logic        wall;
        logic [11:0] ex;
        logic [11:0] ey;
        logic [4:0]  ec;
        logic [3:0]  er;
        logic        ereq;
        logic [4:0]  emc;
        logic [3:0]  emr;
        logic        emv;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input op_e op, input logic [3:0] dirs, input logic wall,
                                input int ex, input int ey, input int ec, input int er,
                                input logic ereq, input int emc, input int emr, input logic emv);
        vec_t v;
        v.op = op; v.dirs = dirs; v.wall = wall;
        v.ex = 12'(ex); v.ey = 12'(ey); v.ec = 5'(ec); v.er = 4'(er);
        v.ereq = ereq; v.emc = 5'(emc); v.emr = 4'(emr); v.emv = emv;
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, " x_pos"},   x_pos,             v.ex);
        chk({tag, " y_pos"},   y_pos,             v.ey);
        chk({tag, " col"},     {7'd0, col},       {7'd0, v.ec});
        chk({tag, " row"},     {8'd0, row},       {8'd0, v.er});
        chk({tag, " map_req"}, {11'd0, map_req},  {11'd0, v.ereq});
        chk({tag, " map_col"}, {7'd0, map_col},   {7'd0, v.emc});
        chk({tag, " map_row"}, {8'd0, map_row},   {8'd0, v.emr});
        chk({tag, " moving"},  {11'd0, moving},   {11'd0, v.emv});
    endtask

    task automatic set_dirs(input logic [3:0] d);
        {dir_up, dir_down, dir_left, dir_right} = d;
    endtask

    task automatic do_rst(input logic [3:0] d);
        @(negedge clk);
        rst = 1'b1;
        vsync_in = 1'b1;
        map_ack = 1'b0;
        set_dirs(d);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_tick(input logic [3:0] d);
        @(negedge clk);
        set_dirs(d);
        vsync_in = 1'b0;
        @(negedge clk);
        vsync_in = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_ack(input logic w);
        @(negedge clk);
        map_ack = 1'b1;
        map_wall = w;
        @(negedge clk);
        map_ack = 1'b0;
        map_wall = 1'b0;
    endtask

    initial begin
        // Reset state, then a free move right from (1,1) to (2,1).
        add(OP_RST,  4'b0000, 1'b0, 40, 40, 1, 1, 1'b0, 0, 0, 1'b0);
        add(OP_TICK, 4'b0001, 1'b0, 40, 40, 1, 1, 1'b1, 2, 1, 1'b0);
        add(OP_ACK,  4'b0001, 1'b0, 40, 40, 1, 1, 1'b0, 2, 1, 1'b1);
        for (int i = 1; i <= 20; i++)
            add(OP_TICK, 4'b0001, 1'b0, 40 + 2 * i, 40, (i == 20) ? 2 : 1, 1,
                1'b0, 2, 1, (i != 20));
        // Wall below: query (1,2), refused, nothing moves.
        add(OP_RST,  4'b0000, 1'b0, 40, 40, 1, 1, 1'b0, 0, 0, 1'b0);
        add(OP_TICK, 4'b0100, 1'b0, 40, 40, 1, 1, 1'b1, 1, 2, 1'b0);
        add(OP_ACK,  4'b0000, 1'b1, 40, 40, 1, 1, 1'b0, 1, 2, 1'b0);
        add(OP_TICK, 4'b0000, 1'b0, 40, 40, 1, 1, 1'b0, 1, 2, 1'b0);
        // Move left to column 0, then keep pushing against the grid edge.
        add(OP_RST,  4'b0000, 1'b0, 40, 40, 1, 1, 1'b0, 0, 0, 1'b0);
        add(OP_TICK, 4'b0010, 1'b0, 40, 40, 1, 1, 1'b1, 0, 1, 1'b0);
        add(OP_ACK,  4'b0010, 1'b0, 40, 40, 1, 1, 1'b0, 0, 1, 1'b1);
        for (int i = 1; i <= 20; i++)
            add(OP_TICK, 4'b0010, 1'b0, 40 - 2 * i, 40, (i == 20) ? 0 : 1, 1,
                1'b0, 0, 1, (i != 20));
        add(OP_TICK, 4'b0010, 1'b0, 0, 40, 0, 1, 1'b0, 0, 1, 1'b0);
        add(OP_TICK, 4'b0010, 1'b0, 0, 40, 0, 1, 1'b0, 0, 1, 1'b0);
        // Top edge: up from row 0 is refused as well.
        add(OP_TICK, 4'b1000, 1'b0, 0, 40, 0, 1, 1'b1, 0, 0, 1'b0);
        add(OP_ACK,  4'b1000, 1'b0, 0, 40, 0, 1, 1'b0, 0, 0, 1'b1);
        for (int i = 1; i <= 20; i++)
            add(OP_TICK, 4'b1000, 1'b0, 0, 40 - 2 * i, 0, (i == 20) ? 0 : 1,
                1'b0, 0, 0, (i != 20));
        add(OP_TICK, 4'b1000, 1'b0, 0, 0, 0, 0, 1'b0, 0, 0, 1'b0);

        repeat (2) @(negedge clk);
        foreach (vq[i]) begin
            case (vq[i].op)
                OP_RST:  do_rst(vq[i].dirs);
                OP_TICK: do_tick(vq[i].dirs);
                default: begin
                    set_dirs(vq[i].dirs);
                    do_ack(vq[i].wall);
                end
            endcase
            chk_all($sformatf("vec%0d", i), vq[i]);
        end

        // No tick may come out of reset release while vsync is already high.
        do_rst(4'b0001);
        repeat (3) @(negedge clk);
        chk("post_rst map_req", {11'd0, map_req}, 12'd0);
        chk("post_rst moving",  {11'd0, moving},  12'd0);
        do_tick(4'b0001);
        chk("post_rst first_tick map_req", {11'd0, map_req}, 12'd1);

        // Up beats left; ack held off for three frames.
        do_rst(4'b0000);
        do_tick(4'b1010);
        chk("prio map_req", {11'd0, map_req}, 12'd1);
        chk("prio map_col", {7'd0, map_col},  12'd1);
        chk("prio map_row", {8'd0, map_row},  12'd0);
        for (int k = 0; k < 3; k++) begin
            do_tick(4'b1010);
            chk($sformatf("slow%0d map_req", k), {11'd0, map_req}, 12'd1);
            chk($sformatf("slow%0d map_col", k), {7'd0, map_col},  12'd1);
            chk($sformatf("slow%0d map_row", k), {8'd0, map_row},  12'd0);
            chk($sformatf("slow%0d moving", k),  {11'd0, moving},  12'd0);
            chk($sformatf("slow%0d y_pos", k),   y_pos,            12'd40);
        end
        do_ack(1'b0);
        chk("slow ack moving",  {11'd0, moving},  12'd1);
        chk("slow ack map_req", {11'd0, map_req}, 12'd0);
        chk("slow ack y_pos",   y_pos,            12'd40);
        do_tick(4'b0000);
        chk("slow first y_pos", y_pos, 12'd38);
        chk("slow first x_pos", x_pos, 12'd40);

        // Reset lands asynchronously in the middle of a right move.
        do_rst(4'b0000);
        do_tick(4'b0001);
        do_ack(1'b0);
        for (int k = 0; k < 7; k++) do_tick(4'b0001);
        chk("midmove x_pos", x_pos, 12'd54);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst x_pos",   x_pos,            12'd40);
        chk("midrst y_pos",   y_pos,            12'd40);
        chk("midrst col",     {7'd0, col},      12'd1);
        chk("midrst moving",  {11'd0, moving},  12'd0);
        chk("midrst map_req", {11'd0, map_req}, 12'd0);
        @(negedge clk);
        rst = 1'b0;
        set_dirs(4'b0000);
        repeat (2) @(negedge clk);
        chk("after midrst moving", {11'd0, moving}, 12'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
